// File: rtl/dr_alm_pipe_signed.sv
// Three-stage signed dynamic-range approximate log multiplier with valid/ready flow control.
// Stage 1 takes magnitudes, stage 2 finds leading-one and mantissa, stage 3 does the antilog and sign.
module dr_alm_pipe_signed #(
   parameter int WIDTH       = 8,
   parameter int TRUNC_WIDTH = 6,
   parameter int APPROX_SIGN = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [2*WIDTH-1:0]   o_z
);

   localparam int KW = $clog2(WIDTH);
   localparam int ZW = 2 * WIDTH;
   localparam int T  = TRUNC_WIDTH;

   function automatic logic [WIDTH-1:0] abs_f(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      if (!v[WIDTH-1])
         r = v;
      else if (APPROX_SIGN != 0)
         r = ~v | {{(WIDTH-1){1'b0}}, 1'b1};
      else
         r = -v;
      return r;
   endfunction

   function automatic logic [KW-1:0] lead_one_f(input logic [WIDTH-1:0] v);
      logic [KW-1:0] k;
      k = '0;
      for (int i = 0; i < WIDTH; i++)
         if (v[i]) k = KW'(i);
      return k;
   endfunction

   function automatic logic [T-1:0] mant_f(input logic [WIDTH-1:0] v, input logic [KW-1:0] k);
      logic [WIDTH-1:0] norm;
      norm = v << (KW'(WIDTH-1) - k);
      return {norm[WIDTH-2 -: T-1], 1'b1};
   endfunction

   // The +1 on the mantissa sum is the dynamic-range bias; its carry bumps the exponent.
   function automatic logic [ZW-1:0] antilog_f(input logic [T-1:0] xa, input logic [T-1:0] xb,
                                               input logic [KW-1:0] ka, input logic [KW-1:0] kb);
      logic [T:0]    sum;
      logic [KW:0]   fk;
      logic [ZW-1:0] m;
      sum = {1'b0, xa} + {1'b0, xb} + {{T{1'b0}}, 1'b1};
      fk  = {1'b0, ka} + {1'b0, kb} + {{KW{1'b0}}, sum[T]};
      m   = ZW'({1'b1, sum[T-1:0]});
      if (int'(fk) >= T)
         return m << (int'(fk) - T);
      else
         return m >> (T - int'(fk));
   endfunction

   function automatic logic [ZW-1:0] sign_f(input logic [ZW-1:0] mag, input logic sgn,
                                            input logic zero);
      logic [ZW-1:0] r;
      if (zero)
         r = '0;
      else if (sgn)
         r = -mag;
      else
         r = mag;
      return r;
   endfunction

   logic signed [WIDTH-1:0] a_s, b_s;
   logic                    stall, advance, accept;

   logic                    vld_p1_q, vld_p2_q, o_valid_q;
   logic                    sign_p1_q, zero_p1_q;
   logic [WIDTH-1:0]        abs_a_p1_q, abs_b_p1_q;
   logic                    sign_p2_q, zero_p2_q;
   logic [KW-1:0]           ka_p2_q, kb_p2_q;
   logic [T-1:0]            xa_p2_q, xb_p2_q;
   logic [ZW-1:0]           z_q;

   logic [KW-1:0]           ka_d, kb_d;
   logic [T-1:0]            xa_d, xb_d;
   logic [ZW-1:0]           z_d;

   assign a_s     = i_a;
   assign b_s     = i_b;
   assign stall   = o_valid_q & ~i_ready;
   assign advance = ~stall;
   assign accept  = i_valid & advance;
   assign o_ready = advance;
   assign o_valid = o_valid_q;
   assign o_z     = z_q;

   assign ka_d = lead_one_f(abs_a_p1_q);
   assign kb_d = lead_one_f(abs_b_p1_q);
   assign xa_d = mant_f(abs_a_p1_q, ka_d);
   assign xb_d = mant_f(abs_b_p1_q, kb_d);
   assign z_d  = sign_f(antilog_f(xa_p2_q, xb_p2_q, ka_p2_q, kb_p2_q), sign_p2_q, zero_p2_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         o_valid_q <= 1'b0;
         z_q       <= '0;
      end else if (advance) begin
         vld_p1_q  <= i_valid;
         vld_p2_q  <= vld_p1_q;
         o_valid_q <= vld_p2_q;
         if (vld_p2_q) z_q <= z_d;
      end
   end

   // stage 1: sign, magnitudes and zero detect
   always_ff @(posedge i_clk) begin
      if (accept) begin
         sign_p1_q  <= a_s[WIDTH-1] ^ b_s[WIDTH-1];
         zero_p1_q  <= (a_s == '0) || (b_s == '0);
         abs_a_p1_q <= abs_f(a_s);
         abs_b_p1_q <= abs_f(b_s);
      end
   end

   // stage 2: leading-one position and truncated mantissa
   always_ff @(posedge i_clk) begin
      if (advance && vld_p1_q) begin
         sign_p2_q <= sign_p1_q;
         zero_p2_q <= zero_p1_q;
         ka_p2_q   <= ka_d;
         kb_p2_q   <= kb_d;
         xa_p2_q   <= xa_d;
         xb_p2_q   <= xb_d;
      end
   end

endmodule

// File: tb/tb_dr_alm_pipe_signed.sv
// Directed and strided-sweep bench for dr_alm_pipe_signed (WIDTH=8, TRUNC_WIDTH=6),
// with an exact-sign and an approximate-sign instance driven in lockstep.
module tb_dr_alm_pipe_signed;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic        i_ready;
   logic [7:0]  i_a, i_b;
   logic        o_ready, o_valid, o_ready_ap, o_valid_ap;
   logic [15:0] o_z, o_z_ap;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_ap_q[$];
   bit          sweep_done;

   typedef struct {
      int          a;
      int          b;
      logic [15:0] ez;
      logic [15:0] ea;
   } vec_t;

   vec_t vt[9] = '{
      '{3,    5,    16'h000E, 16'h000E},
      '{-3,   5,    16'hFFF2, 16'hFFF2},
      '{127,  127,  16'h3F80, 16'h3F80},
      '{-128, -128, 16'h4300, 16'h3F80},
      '{0,    -77,  16'h0000, 16'h0000},
      '{-1,   1,    16'hFFFF, 16'hFFFF},
      '{-4,   1,    16'hFFFC, 16'hFFFD},
      '{-128, 1,    16'hFF7A, 16'hFF7E},
      '{100,  -50,  16'hED40, 16'hEDC0}
   };

   dr_alm_pipe_signed #(.WIDTH(8), .TRUNC_WIDTH(6), .APPROX_SIGN(0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready), .o_z(o_z));

   dr_alm_pipe_signed #(.WIDTH(8), .TRUNC_WIDTH(6), .APPROX_SIGN(1)) u_dut_ap (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready_ap),
      .i_a(i_a), .i_b(i_b), .o_valid(o_valid_ap), .i_ready(i_ready), .o_z(o_z_ap));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input int a, input int b, input bit ap);
      int aa, ab, ka, kb, xa, xb, sum, c, fk, m, mag;
      bit sg;
      if (a == 0 || b == 0) return 16'h0000;
      sg = (a < 0) != (b < 0);
      aa = (a < 0) ? (ap ? (((~a) & 255) | 1) : -a) : a;
      ab = (b < 0) ? (ap ? (((~b) & 255) | 1) : -b) : b;
      ka = 0;
      kb = 0;
      for (int i = 0; i < 8; i++) begin
         if (((aa >> i) & 1) != 0) ka = i;
         if (((ab >> i) & 1) != 0) kb = i;
      end
      xa  = ((((aa << (7 - ka)) & 255) >> 2) & 31) * 2 + 1;
      xb  = ((((ab << (7 - kb)) & 255) >> 2) & 31) * 2 + 1;
      sum = xa + xb + 1;
      c   = (sum >> 6) & 1;
      fk  = ka + kb + c;
      m   = 64 | (sum & 63);
      mag = (fk >= 6) ? (m << (fk - 6)) : (m >> (6 - fk));
      return sg ? 16'(-mag) : 16'(mag);
   endfunction

   // Scoreboard: every consumed result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && o_valid && i_ready) begin
         if (exp_q.size() == 0)
            chk("unexpected_out", 16'(o_valid), 16'h0000);
         else begin
            chk("z_exact", o_z, exp_q.pop_front());
            chk("z_approx", o_z_ap, exp_ap_q.pop_front());
         end
      end
   end

   task automatic send(input int a, input int b, input logic [15:0] ez, input logic [15:0] ea);
      int  n;
      bit  acc;
      n       = 0;
      i_valid = 1'b1;
      i_a     = 8'(a);
      i_b     = 8'(b);
      exp_q.push_back(ez);
      exp_ap_q.push_back(ea);
      while (1) begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         n++;
         if (n > 100) begin
            chk("accept_timeout", 16'h0001, 16'h0000);
            break;
         end
      end
      i_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(tag, 16'(exp_q.size()), 16'h0000);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      i_valid    = 1'b0;
      i_ready    = 1'b1;
      i_a        = '0;
      i_b        = '0;
      sweep_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 16'(o_valid), 16'h0000);
      chk("rst_z", o_z, 16'h0000);
      chk("rst_ready", 16'(o_ready), 16'h0001);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(vt[0].a, vt[0].b, vt[0].ez, vt[0].ea);
      @(negedge clk);
      chk("lat_e0", 16'(o_valid), 16'h0000);
      @(negedge clk);
      chk("lat_e1", 16'(o_valid), 16'h0000);
      @(negedge clk);
      chk("lat_e2", 16'(o_valid), 16'h0001);
      @(posedge clk);
      #1;
      for (int i = 1; i < 9; i++) send(vt[i].a, vt[i].b, vt[i].ez, vt[i].ea);
      drain("drain_directed");

      fork
         begin
            for (int i = 0; i < 10; i++)
               send(i + 1, (i % 2 != 0) ? -1 : 1,
                    (i % 2 != 0) ? 16'(-(i + 1)) : 16'(i + 1),
                    (i % 2 != 0) ? 16'(-(i + 1)) : 16'(i + 1));
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            i_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("bp_ready", 16'(o_ready), 16'h0000);
               chk("bp_valid", 16'(o_valid), 16'h0001);
               chk("bp_hold", o_z, exp_q[0]);
            end
            @(posedge clk);
            #1;
            i_ready = 1'b1;
         end
      join
      drain("drain_bp");

      send(3, 5, 16'h000E, 16'h000E);
      send(-3, 5, 16'hFFF2, 16'hFFF2);
      send(127, 127, 16'h3F80, 16'h3F80);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 16'(o_valid), 16'h0000);
      chk("midrst_z", o_z, 16'h0000);
      chk("midrst_ready", 16'(o_ready), 16'h0001);
      exp_q.delete();
      exp_ap_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stale_valid", 16'(o_valid), 16'h0000);
      end
      @(posedge clk);
      #1;
      send(-4, 1, 16'hFFFC, 16'hFFFD);
      drain("drain_post_rst");

      fork
         begin
            for (int a = -128; a < 128; a++)
               for (int b = -128; b < 128; b += 5)
                  send(a, b, model(a, b, 1'b0), model(a, b, 1'b1));
            sweep_done = 1'b1;
         end
         begin
            while (!sweep_done) begin
               @(posedge clk);
               #1;
               i_ready = ($urandom_range(3) != 0);
            end
         end
      join
      i_ready = 1'b1;
      drain("drain_sweep");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
